riscv_reg_file: RTL and testbench

//   RV32I integer register file: 32 x 32-bit registers, two asynchronous read

---
 rtl/riscv_reg_file.sv | 68 ++++++
 tb/tb_riscv_reg_file.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/riscv_reg_file.sv
// RV32I integer register file: x1..x31 are per-register entries built in a generate loop,
// x0 is a constant zero. Two combinational read ports, one synchronous write port.

module riscv_reg_file_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (wr_en) data_d = wr_data;
  end

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

module riscv_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // x0 has no storage, so writes to it vanish and reads return zero.
  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    riscv_reg_file_entry #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en && (wr_reg == ADDR_WIDTH'(i))),
      .wr_data(wr_data),
      .data   (regs[i])
    );
  end

  // No write-through bypass: reads see the array as it stands before the edge.
  assign rd_data_1 = regs[rd_reg_1];
  assign rd_data_2 = regs[rd_reg_2];

endmodule

// File: tb/tb_riscv_reg_file.sv
// Bench for riscv_reg_file: array reference model checked on every falling edge,
// plus directed vectors with literal expected values.

module tb_riscv_reg_file;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_reg_1;
  logic [AW-1:0] rd_reg_2;
  logic [DW-1:0] rd_data_1;
  logic [DW-1:0] rd_data_2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mdl [NR];
  bit            mdl_valid = 1'b0;

  riscv_reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_reg_1 (rd_reg_1),
    .rd_reg_2 (rd_reg_2),
    .rd_data_1(rd_data_1),
    .rd_data_2(rd_data_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] idx);
    return (idx == '0) ? '0 : mdl[idx];
  endfunction

  // Reference model: plain array updated on the edge, x0 never stored.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) mdl[k] = '0;
      mdl_valid = 1'b1;
    end else if (wr_en && wr_reg != '0) begin
      mdl[wr_reg] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      check("model_port1", rd_data_1, model_rd(rd_reg_1));
      check("model_port2", rd_data_2, model_rd(rd_reg_2));
    end
  end

  task automatic wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_reg  = r;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_reg_1 = a;
    rd_reg_2 = b;
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_reg   = '0;
    wr_data  = '0;
    rd_reg_1 = '0;
    rd_reg_2 = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset clears every register on both ports.
    for (int i = 0; i < NR; i++) begin
      rd(AW'(i), AW'(NR - 1 - i));
      check("reset_p1", rd_data_1, 32'h0);
      check("reset_p2", rd_data_2, 32'h0);
    end

    // Basic write then read on both ports.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    check("wr_rd_p1", rd_data_1, 32'hDEADBEEF);
    check("wr_rd_p2", rd_data_2, 32'hDEADBEEF);

    // x0 ignores writes.
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    check("x0_p1", rd_data_1, 32'h0);
    check("x0_p2", rd_data_2, 32'h0);

    // wr_en=0 leaves the register untouched.
    wr(5'd7, 32'h1234);
    wr_en = 1'b0; wr_reg = 5'd7; wr_data = 32'hFFFF;
    @(posedge clk); #1;
    rd(5'd7, 5'd5);
    check("wr_dis_x7", rd_data_1, 32'h1234);
    check("wr_dis_x5", rd_data_2, 32'hDEADBEEF);

    // Read-during-write returns the old value until the edge.
    wr(5'd3, 32'hA);
    wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'hB;
    rd(5'd3, 5'd7);
    check("rdw_before", rd_data_1, 32'hA);
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("rdw_after", rd_data_1, 32'hB);

    // Independent ports and top index.
    wr(5'd10, 32'h55);
    wr(5'd31, 32'h8000_0001);
    rd(5'd10, 5'd31);
    check("indep_p1", rd_data_1, 32'h55);
    check("indep_p2", rd_data_2, 32'h8000_0001);

    // Reset has priority over a simultaneous write.
    rst = 1'b1; wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'h99;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    rd(5'd9, 5'd5);
    check("rst_prio_x9", rd_data_1, 32'h0);
    check("rst_clr_x5", rd_data_2, 32'h0);

    // Random regression, checked by the model on every falling edge.
    for (int i = 0; i < 1000; i++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_reg  = AW'($urandom_range(0, NR - 1));
      wr_data = $urandom;
      if (i % 50 == 0) wr_reg = '0;
      if (i < NR) begin
        rd_reg_1 = AW'(i);
        rd_reg_2 = AW'(NR - 1 - i);
      end else begin
        rd_reg_1 = ($urandom_range(0, 3) == 0) ? wr_reg : AW'($urandom_range(0, NR - 1));
        rd_reg_2 = ($urandom_range(0, 3) == 0) ? wr_reg : AW'($urandom_range(0, NR - 1));
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
